// File: rtl/xadc_sample_axil_slave.sv
// AXI4-Lite responder that buffers XADC conversion results in a sample FIFO for the PS.
// Optional per-sample eoc timestamp in DATA[30:16] when XADC_SAMPLE_TIMESTAMP_EN is defined.
module xadc_sample_axil_slave #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
    parameter int unsigned FIFO_DEPTH         = 16,
    parameter int unsigned SAMPLE_WIDTH       = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [SAMPLE_WIDTH-1:0]         val_i,
    input  logic                            eoc_i,
    output logic                            irq_o,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready
);

    localparam int unsigned IDX_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W  = IDX_W + 1;
    localparam int unsigned STRB_W = C_S_AXI_DATA_WIDTH / 8;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    // Write channel
    w_state_t                        r_w_state, w_w_state_nxt;
    logic                            r_awready, w_awready_nxt;
    logic                            r_wready, w_wready_nxt;
    logic                            r_bvalid, w_bvalid_nxt;
    logic                            r_aw_held, w_aw_held_nxt;
    logic                            r_wd_held, w_wd_held_nxt;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   r_awaddr;
    logic [C_S_AXI_DATA_WIDTH-1:0]   r_wdata;
    logic [STRB_W-1:0]               r_wstrb;
    logic                            w_aw_hs, w_w_hs, w_do_write;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   w_wr_addr;
    logic [C_S_AXI_DATA_WIDTH-1:0]   w_wr_data;
    logic [STRB_W-1:0]               w_wr_strb;
    logic [1:0]                      w_wr_sel;

    // Read channel
    r_state_t                        r_r_state, w_r_state_nxt;
    logic                            r_arready, w_arready_nxt;
    logic                            r_rvalid, w_rvalid_nxt;
    logic [C_S_AXI_DATA_WIDTH-1:0]   r_rdata;
    logic [C_S_AXI_DATA_WIDTH-1:0]   w_rd_word;
    logic                            w_ar_hs;
    logic [1:0]                      w_rd_sel;

    // Control/status and FIFO
    logic                            r_en, r_irq_en, r_ovf, r_irq;
    logic [7:0]                      r_thresh;
    logic [PTR_W-1:0]                r_wr_ptr, r_rd_ptr;
    logic [PTR_W-1:0]                w_count;
    logic [7:0]                      w_count8;
    logic [IDX_W-1:0]                w_wr_idx, w_rd_idx;
    logic                            w_empty, w_full;
    logic                            w_push, w_pop, w_clr, w_ovf_set, w_ovf_clr;
    logic [SAMPLE_WIDTH-1:0]         r_mem [FIFO_DEPTH];
    logic                            w_unused;

    assign w_aw_hs   = s_axi_awvalid && r_awready;
    assign w_w_hs    = s_axi_wvalid && r_wready;
    // Either half may arrive on the commit edge itself, so fall through to the live bus.
    assign w_wr_addr = r_aw_held ? r_awaddr : s_axi_awaddr;
    assign w_wr_data = r_wd_held ? r_wdata : s_axi_wdata;
    assign w_wr_strb = r_wd_held ? r_wstrb : s_axi_wstrb;
    assign w_wr_sel  = w_wr_addr[3:2];

    always_comb begin
        w_w_state_nxt = r_w_state;
        w_awready_nxt = r_awready;
        w_wready_nxt  = r_wready;
        w_bvalid_nxt  = r_bvalid;
        w_aw_held_nxt = r_aw_held | w_aw_hs;
        w_wd_held_nxt = r_wd_held | w_w_hs;
        w_do_write    = 1'b0;
        unique case (r_w_state)
            W_IDLE: begin
                if (w_aw_held_nxt && w_wd_held_nxt) begin
                    w_do_write    = 1'b1;
                    w_aw_held_nxt = 1'b0;
                    w_wd_held_nxt = 1'b0;
                    w_awready_nxt = 1'b0;
                    w_wready_nxt  = 1'b0;
                    w_bvalid_nxt  = 1'b1;
                    w_w_state_nxt = W_RESP;
                end else begin
                    w_awready_nxt = !w_aw_held_nxt;
                    w_wready_nxt  = !w_wd_held_nxt;
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    w_bvalid_nxt  = 1'b0;
                    w_awready_nxt = 1'b1;
                    w_wready_nxt  = 1'b1;
                    w_w_state_nxt = W_IDLE;
                end
            end
            default: w_w_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_w_state <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_aw_held <= 1'b0;
            r_wd_held <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            r_w_state <= w_w_state_nxt;
            r_awready <= w_awready_nxt;
            r_wready  <= w_wready_nxt;
            r_bvalid  <= w_bvalid_nxt;
            r_aw_held <= w_aw_held_nxt;
            r_wd_held <= w_wd_held_nxt;
            if (w_aw_hs) r_awaddr <= s_axi_awaddr;
            if (w_w_hs) begin
                r_wdata <= s_axi_wdata;
                r_wstrb <= s_axi_wstrb;
            end
        end
    end

    assign w_ar_hs  = s_axi_arvalid && r_arready;
    assign w_rd_sel = s_axi_araddr[3:2];

    always_comb begin
        w_r_state_nxt = r_r_state;
        w_arready_nxt = r_arready;
        w_rvalid_nxt  = r_rvalid;
        unique case (r_r_state)
            R_IDLE: begin
                if (w_ar_hs) begin
                    w_arready_nxt = 1'b0;
                    w_rvalid_nxt  = 1'b1;
                    w_r_state_nxt = R_DATA;
                end else begin
                    w_arready_nxt = 1'b1;
                end
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    w_rvalid_nxt  = 1'b0;
                    w_arready_nxt = 1'b1;
                    w_r_state_nxt = R_IDLE;
                end
            end
            default: w_r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_r_state <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_r_state <= w_r_state_nxt;
            r_arready <= w_arready_nxt;
            r_rvalid  <= w_rvalid_nxt;
            if (w_ar_hs) r_rdata <= w_rd_word;
        end
    end

    assign w_count  = r_wr_ptr - r_rd_ptr;
    assign w_count8 = 8'(w_count);
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (w_count == PTR_W'(FIFO_DEPTH));
    assign w_wr_idx = r_wr_ptr[IDX_W-1:0];
    assign w_rd_idx = r_rd_ptr[IDX_W-1:0];

    assign w_clr     = w_do_write && (w_wr_sel == 2'd0) && w_wr_strb[0] && w_wr_data[1];
    assign w_ovf_clr = w_do_write && (w_wr_sel == 2'd1) && w_wr_strb[2] && w_wr_data[16];
    assign w_pop     = w_ar_hs && (w_rd_sel == 2'd2) && !w_empty;
    // A pop in the same cycle frees the slot the push needs; a flush discards the sample.
    assign w_push    = eoc_i && r_en && !w_clr && (!w_full || w_pop);
    assign w_ovf_set = eoc_i && r_en && !w_clr && w_full && !w_pop;

`ifdef XADC_SAMPLE_TIMESTAMP_EN
    logic [14:0] r_ts;
    logic [14:0] r_ts_mem [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (rst || w_clr) begin
            r_ts <= '0;
        end else if (eoc_i && r_en) begin
            r_ts <= r_ts + 15'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_ts_mem[w_wr_idx] <= r_ts;
    end
`endif

    always_comb begin
        w_rd_word = '0;
        case (w_rd_sel)
            2'd0: begin
                w_rd_word[0] = r_en;
                w_rd_word[2] = r_irq_en;
            end
            2'd1: begin
                w_rd_word[7:0] = w_count8;
                w_rd_word[8]   = w_empty;
                w_rd_word[9]   = w_full;
                w_rd_word[16]  = r_ovf;
            end
            2'd2: begin
                if (!w_empty) begin
                    w_rd_word[31]                 = 1'b1;
                    w_rd_word[SAMPLE_WIDTH-1:0]   = r_mem[w_rd_idx];
`ifdef XADC_SAMPLE_TIMESTAMP_EN
                    w_rd_word[30:16]              = r_ts_mem[w_rd_idx];
`endif
                end
            end
            default: w_rd_word[7:0] = r_thresh;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[w_wr_idx] <= val_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_en     <= 1'b0;
            r_irq_en <= 1'b0;
            r_thresh <= '0;
            r_ovf    <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_irq    <= 1'b0;
        end else begin
            if (w_do_write && (w_wr_sel == 2'd0) && w_wr_strb[0]) begin
                r_en     <= w_wr_data[0];
                r_irq_en <= w_wr_data[2];
            end
            if (w_do_write && (w_wr_sel == 2'd3) && w_wr_strb[0]) begin
                r_thresh <= w_wr_data[7:0];
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
            if (w_clr) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_irq <= r_irq_en && (r_thresh != 8'd0) && (w_count8 >= r_thresh);
        end
    end

    assign w_unused = ^{w_wr_addr[1:0], s_axi_araddr[1:0], w_wr_data[31:17], w_wr_data[15:8],
                        w_wr_strb[3], w_wr_strb[1]};

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = 2'b00;
    assign irq_o         = r_irq;

endmodule
